// File: rtl/bsk_pkg.sv
// Shared BSK PRD board definitions: command word geometry, idle value and the
// per-channel debounce decision used by the command-line filter.
package bsk_pkg;

  localparam int BSK_COM_WIDTH = 16;
  localparam logic [BSK_COM_WIDTH-1:0] BSK_COM_DEFAULT = 16'hFFFF;

  typedef logic [BSK_COM_WIDTH-1:0] bsk_com_t;

  // What one synchronised sample does to a channel's debounce state.
  typedef enum logic [1:0] {
    DEB_MATCH,   // sample equals accepted level: restart the count
    DEB_COUNT,   // sample differs, run not yet long enough
    DEB_ACCEPT   // sample differs and completes the run: take the new level
  } deb_act_e;

endpackage

// File: rtl/bsk_com_debounce.sv
// One command channel: two-flop synchroniser, consecutive-sample debounce,
// hold-able output bit and sticky change flag.
module bsk_com_debounce
  import bsk_pkg::*;
#(
  parameter int   FILTER_LEN = 4,
  parameter int   CNT_W      = 8,
  parameter logic RST_VAL    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic com_i,
  input  logic hold_i,
  input  logic clr_chg_i,
  output logic com_o,
  output logic chg_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             s1_d, s1_q;
  logic             s2_d, s2_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             filt_d, filt_q;
  logic             com_d, com_q;
  logic             chg_d, chg_q;
  deb_act_e         act;

  always_comb begin
    if (s2_q == filt_q)       act = DEB_MATCH;
    else if (cnt_q == CNT_LAST) act = DEB_ACCEPT;
    else                      act = DEB_COUNT;
  end

  // NOTE: every signal gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    s1_d   = com_i;
    s2_d   = s1_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    unique case (act)
      DEB_MATCH:  cnt_d = '0;
      DEB_COUNT:  cnt_d = cnt_q + CNT_W'(1);
      DEB_ACCEPT: begin
        filt_d = s2_q;
        cnt_d  = '0;
      end
      default:    cnt_d = '0;
    endcase

    com_d = hold_i ? com_q : filt_q;

    // A toggle on this edge outranks a simultaneous clear.
    if (com_d != com_q) chg_d = 1'b1;
    else if (clr_chg_i) chg_d = 1'b0;
    else                chg_d = chg_q;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would let s2 see this edge's s1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      cnt_q  <= '0;
      filt_q <= RST_VAL;
      com_q  <= RST_VAL;
      chg_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      com_q  <= com_d;
      chg_q  <= chg_d;
    end
  end

  assign com_o = com_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/bsk_com_filter.sv
// Input conditioning for the PRD board command lines: per-channel sync and
// debounce, read-coherent command word and sticky change flags.
module bsk_com_filter
  import bsk_pkg::*;
#(
  parameter int               WIDTH       = BSK_COM_WIDTH,
  parameter int               FILTER_LEN  = 4,
  parameter int               CNT_W       = 8,
  parameter logic [WIDTH-1:0] COM_DEFAULT = BSK_COM_DEFAULT
) (
  input  logic             clk,
  input  logic             iRes,
  input  logic [WIDTH-1:0] iCom,
  input  logic             iHold,
  input  logic             iClrChg,
  output logic [WIDTH-1:0] oCom,
  output logic [WIDTH-1:0] oChg,
  output logic             oChgAny
);

  // The counter must be able to hold FILTER_LEN-1 and at least one sample is needed.
  if (FILTER_LEN < 1 || FILTER_LEN >= (1 << CNT_W)) begin : g_param_err
    $error("bsk_com_filter: FILTER_LEN=%0d illegal for CNT_W=%0d", FILTER_LEN, CNT_W);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    bsk_com_debounce #(
      .FILTER_LEN (FILTER_LEN),
      .CNT_W      (CNT_W),
      .RST_VAL    (COM_DEFAULT[i])
    ) u_deb (
      .clk       (clk),
      .rst_n     (iRes),
      .com_i     (iCom[i]),
      .hold_i    (iHold),
      .clr_chg_i (iClrChg),
      .com_o     (oCom[i]),
      .chg_o     (oChg[i])
    );
  end

  assign oChgAny = |oChg;

endmodule
